// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register-file write side.
//   REG_WIDTH / REG_DEPTH / REG_AW : data width, register count, address width
//   state_e                        : sweep-clear sequencer states
//   ZERO_REG                       : index of the hardwired-zero register
package regfile_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_AW    = 5;

  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_port_addr_decoder.sv
// addr_decoder
// Combinational AW-to-DEPTH one-hot decoder with enable.
//   en_i     : enable; output is all-zero when low
//   addr_i   : index to decode
//   onehot_o : one-hot select, bit addr_i set when enabled
module addr_decoder #(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [DEPTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port
// Write side of the general-purpose register file, with a sweep-clear
// sequencer that zeroes every register one per cycle on request.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   we        : write request, held until wr_ack
//   waddr     : target register index
//   wdata     : write data
//   clr_req   : one-cycle pulse starting a sweep-clear
//   wr_ack    : pulse, write accepted on the previous edge
//   busy      : sweep-clear in progress
//   wsel      : registered one-hot of the last accepted write
//   regs_flat : register i at bits [i*WIDTH +: WIDTH]
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int DEPTH = REG_DEPTH,
  parameter int AW    = REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   clr_req,
  output logic                   wr_ack,
  output logic                   busy,
  output logic [DEPTH-1:0]       wsel,
  output logic [DEPTH*WIDTH-1:0] regs_flat
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wr_ack_q, wr_ack_d;
  logic [DEPTH-1:0] wsel_q, wsel_d;
  logic             accept;
  logic             clearing;
  logic [DEPTH-1:0] load_en;

  // Register 0 has no storage; it is tied to zero on the output.
  logic [WIDTH-1:0] regs_q [ZERO_REG+1:DEPTH-1];

  // A clear request takes priority over a concurrent write in IDLE.
  assign accept   = (state_q == IDLE) && we && !clr_req;
  assign clearing = (state_q == CLEAR);

  addr_decoder #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_addr_decoder (
    .en_i     (accept),
    .addr_i   (waddr),
    .onehot_o (load_en)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ack_d = accept;
    wsel_d   = load_en;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          // Register 0 is already zero, so the sweep starts at 1.
          cnt_d   = AW'(ZERO_REG + 1);
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ack_q <= 1'b0;
      wsel_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ack_q <= wr_ack_d;
      wsel_q   <= wsel_d;
    end
  end

  // Writes and the sweep are mutually exclusive (load_en is zero in CLEAR).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = ZERO_REG + 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = ZERO_REG + 1; i < DEPTH; i++) begin
        if (load_en[i]) begin
          regs_q[i] <= wdata;
        end else if (clearing && (cnt_q == AW'(i))) begin
          regs_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    regs_flat[ZERO_REG*WIDTH +: WIDTH] = '0;
    for (int unsigned i = ZERO_REG + 1; i < DEPTH; i++) begin
      regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  assign wr_ack = wr_ack_q;
  assign busy   = clearing;
  assign wsel   = wsel_q;

endmodule

// File: tb/tb_regfile_write_port.sv
module tb_regfile_write_port;

  logic          clk;
  logic          rst;
  logic          we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          clr_req;
  logic          wr_ack;
  logic          busy;
  logic [31:0]   wsel;
  logic [1023:0] regs_flat;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the register file as a plain array.
  logic [31:0] m [32];

  regfile_write_port #(
    .WIDTH (32),
    .DEPTH (32),
    .AW    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .clr_req   (clr_req),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .wsel      (wsel),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1023:0] pack_model();
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = m[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) m[a] = d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    #2;
    checks++; if (regs_flat !== 1024'h0) begin errors++; $display("FAIL por_regs got=%h exp=0", regs_flat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL por_busy got=%b exp=0", busy); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL por_ack got=%b exp=0", wr_ack); end
    checks++; if (wsel !== 32'h0) begin errors++; $display("FAIL por_wsel got=%h exp=0", wsel); end
    @(negedge clk);
    rst = 1'b0;
    // Put state into the DUT, then reset mid-cycle with no clock edge.
    d = $urandom | 32'h1;
    we = 1'b1; waddr = 5'd9; wdata = d;
    tick();
    we = 1'b0;
    model_write(5'd9, d);
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL pre_reset_write got=%h exp=%h", regs_flat[319:288], d); end
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    checks++; if (regs_flat !== 1024'h0) begin errors++; $display("FAIL async_reset_regs got=%h exp=0", regs_flat[319:288]); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL async_reset_ack got=%b exp=0", wr_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    checks++; if (wsel !== 32'h0) begin errors++; $display("FAIL async_reset_wsel got=%h exp=0", wsel); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_write();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    model_write(5'd5, 32'hDEADBEEF);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL basic_ack got=%b exp=1", wr_ack); end
    checks++; if (wsel !== 32'h20) begin errors++; $display("FAIL basic_wsel got=%h exp=00000020", wsel); end
    checks++; if (regs_flat[191:160] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_reg5 got=%h exp=deadbeef", regs_flat[191:160]); end
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL basic_others got=%h exp=%h", regs_flat, pack_model()); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL basic_ack_drop got=%b exp=0", wr_ack); end
    checks++; if (wsel !== 32'h0) begin errors++; $display("FAIL basic_wsel_drop got=%h exp=0", wsel); end
  endtask

  task automatic test_reg0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL reg0_ack got=%b exp=1", wr_ack); end
    checks++; if (wsel !== 32'h1) begin errors++; $display("FAIL reg0_wsel got=%h exp=00000001", wsel); end
    checks++; if (regs_flat[31:0] !== 32'h0) begin errors++; $display("FAIL reg0_value got=%h exp=0", regs_flat[31:0]); end
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL reg0_others got=%h exp=%h", regs_flat, pack_model()); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] addrs [4];
    addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd3; addrs[3] = 5'd31;
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; waddr = addrs[k]; wdata = 32'(k + 1);
      tick();
      model_write(addrs[k], 32'(k + 1));
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=1", k, wr_ack); end
      checks++; if (wsel !== (32'h1 << addrs[k])) begin errors++; $display("FAIL b2b_wsel[%0d] got=%h exp=%h", k, wsel, 32'h1 << addrs[k]); end
    end
    we = 1'b0;
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL b2b_regs got=%h exp=%h", regs_flat, pack_model()); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got=%b exp=0", wr_ack); end
  endtask

  task automatic test_random_writes();
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    for (int k = 0; k < 200; k++) begin
      w = ($urandom_range(0, 3) != 0);
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      we = w; waddr = a; wdata = d;
      tick();
      if (w) model_write(a, d);
      checks++; if (wr_ack !== w) begin errors++; $display("FAIL rand_ack[%0d] got=%b exp=%b", k, wr_ack, w); end
      checks++; if (wsel !== (w ? (32'h1 << a) : 32'h0)) begin errors++; $display("FAIL rand_wsel[%0d] got=%h addr=%0d we=%b", k, wsel, a, w); end
      checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL rand_regs[%0d] got=%h exp=%h", k, regs_flat, pack_model()); end
    end
    we = 1'b0;
  endtask

  task automatic fill_nonzero();
    logic [31:0] d;
    for (int i = 1; i < 32; i++) begin
      d = $urandom | 32'h1;
      we = 1'b1; waddr = 5'(i); wdata = d;
      tick();
      model_write(5'(i), d);
    end
    we = 1'b0;
    tick();
  endtask

  task automatic test_sweep_clear();
    int busy_cycles;
    bit ack_seen;
    fill_nonzero();
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL sweep_fill got=%h exp=%h", regs_flat, pack_model()); end
    clr_req = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'h55;
    tick();
    clr_req = 1'b0;
    busy_cycles = 0;
    ack_seen = 1'b0;
    while (busy === 1'b1 && busy_cycles < 64) begin
      busy_cycles++;
      if (wr_ack !== 1'b0) ack_seen = 1'b1;
      // A clear request mid-sweep must not restart it.
      clr_req = (busy_cycles == 15);
      tick();
    end
    clr_req = 1'b0;
    model_clear();
    checks++; if (busy_cycles != 31) begin errors++; $display("FAIL sweep_busy_len got=%0d exp=31", busy_cycles); end
    checks++; if (ack_seen) begin errors++; $display("FAIL sweep_ack_while_busy got=1 exp=0"); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL sweep_ack_at_end got=%b exp=0", wr_ack); end
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL sweep_cleared got=%h exp=0", regs_flat); end
    tick();
    we = 1'b0;
    model_write(5'd7, 32'h55);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL stalled_ack got=%b exp=1", wr_ack); end
    checks++; if (wsel !== 32'h80) begin errors++; $display("FAIL stalled_wsel got=%h exp=00000080", wsel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stalled_busy got=%b exp=0", busy); end
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL stalled_regs got=%h exp=%h", regs_flat, pack_model()); end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] d;
    fill_nonzero();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsweep_busy got=%b exp=1", busy); end
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midsweep_reset_busy got=%b exp=0", busy); end
    checks++; if (regs_flat !== 1024'h0) begin errors++; $display("FAIL midsweep_reset_regs got=%h exp=0", regs_flat); end
    @(negedge clk);
    rst = 1'b0;
    d = $urandom | 32'h1;
    we = 1'b1; waddr = 5'd3; wdata = d;
    tick();
    we = 1'b0;
    model_write(5'd3, d);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack got=%b exp=1", wr_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    checks++; if (regs_flat !== pack_model()) begin errors++; $display("FAIL post_reset_regs got=%h exp=%h", regs_flat[127:96], d); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
    model_clear();
    test_reset();
    test_basic_write();
    test_reg0();
    test_back_to_back();
    test_random_writes();
    test_sweep_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
Write side of the 32x32 general-purpose register file. Decodes a 5-bit write address into a one-hot enable and stores write data into the addressed register. Also contains a sweep-clear sequencer that zeroes the whole file on request. The 32 register values are driven out flat to the read-side 32:1 selectors.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers; fixed at 2**AW
AW, 5, write address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
we  in  1  write request; held high until wr_ack is seen
waddr  in  AW  target register index
wdata  in  WIDTH  write data
clr_req  in  1  single-cycle pulse requesting a sweep-clear of all registers
wr_ack  out  1  one-cycle pulse; the write request was accepted on the previous edge
busy  out  1  high while the sweep-clear is in progress
wsel  out  DEPTH  registered one-hot copy of the last accepted write enable (debug and hazard tap)
regs_flat  out  DEPTH*WIDTH  all register contents; register i occupies bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset (asynchronous, rst=1):
  - All registers 0; wr_ack=0, busy=0, wsel=0.
  - FSM goes to IDLE; clear counter goes to 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- FSM states: IDLE, CLEAR.
- IDLE, clr_req=1:
  - Next state is CLEAR; counter loads 1; busy=1 from the next cycle.
  - A concurrent we is NOT accepted: wr_ack stays 0 and the initiator keeps we high.
- IDLE, we=1, clr_req=0:
  - Write is accepted at this edge: reg[waddr] <= wdata.
  - Next cycle: wr_ack=1, and wsel = one-hot(waddr).
- IDLE, no request: wr_ack=0 and wsel=0 on the next edge.
- Register 0:
  - Hardwired to zero; a write to address 0 is discarded.
  - That write is still acknowledged (wr_ack=1, wsel=32'h1).
- Back-to-back writes: if we stays high in IDLE, a write is accepted on every edge and wr_ack stays high continuously.
- CLEAR:
  - Each cycle: reg[counter] <= 0, then counter increments.
  - At counter=31, reg[31] clears and the FSM returns to IDLE.
  - busy is high for exactly 31 cycles, counted from the edge after clr_req.
- During CLEAR:
  - we is stalled (no wr_ack, no register change).
  - The stalled write is accepted on the first IDLE edge.
  - clr_req is ignored (no restart).
- Latency: a write is visible on regs_flat one cycle after the accepting edge, at the same time as wr_ack.
- Write-after-clear ordering: a write accepted on the first IDLE edge after CLEAR overwrites the zero.
- waddr width equals AW; no out-of-range addresses exist.
- No combinational path from the inputs to any output.

Decomposition:
- Shared package regfile_pkg:
  - Constants REG_WIDTH=32, REG_DEPTH=32, REG_AW=5.
  - FSM state enum {IDLE, CLEAR}.
  - ZERO_REG=0.
- Sub-module addr_decoder: combinational, AW-to-DEPTH one-hot decoder with an enable input; output is all-zero when the enable is low.
  - Instantiated once.
  - Its enable is driven by the IDLE write-accept condition.
  - It drives the per-register load enables and the wsel register.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> regs_flat=0, busy=0, wr_ack=0 immediately, without waiting for a clock edge.
- Basic write: we=1, waddr=5, wdata=32'hDEADBEEF for 1 cycle -> next cycle wr_ack=1, wsel=32'h20, regs_flat[191:160]=32'hDEADBEEF; all other registers unchanged.
- Register 0: write 32'hFFFFFFFF to address 0 -> wr_ack=1, wsel=32'h1, regs_flat[31:0] stays 0.
- Back-to-back: four consecutive writes to addresses 1,2,3,31 with values 1,2,3,4 -> wr_ack high for 4 cycles, and each register holds its value.
- Sweep-clear with stalled write:
  - Stimulus: fill registers 1..31 with nonzero values, pulse clr_req, and hold we=1, waddr=7, wdata=32'h55 during the sweep.
  - Required: busy high for 31 cycles and no wr_ack while busy; all registers 0 afterward except reg7=32'h55, which is written on the first IDLE edge with wr_ack=1.
- Reset mid-sweep: assert rst at sweep cycle 10 -> busy=0 and all registers 0 immediately; after release, the FSM is in IDLE and a write to address 3 is accepted normally.
